// File: rtl/vend_pkg.sv
// Shared coin codes and acceptor state encoding for the vending front end.
// Imported by coin_debounce and coin_acceptor.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    GUARD
  } acc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser, debounce counter and rising-edge detect for one sensor.
// Ports: clk, rst (sync, active high), raw (async sensor), rise (one-cycle event).
module coin_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q, lvl_d;
  logic          dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive synced samples that disagree with the accepted level;
  // any agreeing sample restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      dly_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      dly_q <= lvl_q;
      cnt_q <= cnt_d;
    end
  end

  assign rise = lvl_q & ~dly_q;

endmodule

// File: rtl/coin_acceptor.sv
// Debounces the coin sensors, queues one transaction and replays it gap-free.
// Ports: clk, rst, coin5_raw, coin10_raw -> coin_code, busy, reject[, reject_cnt].
// Optional reject counter enabled by defining COIN_REJECT_COUNT_EN.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDLE_TIMEOUT    = 1000,
  parameter int DEPTH           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic [1:0] coin_code,
  output logic       busy,
  output logic       reject
`ifdef COIN_REJECT_COUNT_EN
  ,
  output logic [7:0] reject_cnt
`endif
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic ev5, ev10, any_ev, both_ev;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clk (clk),
    .rst (rst),
    .raw (coin5_raw),
    .rise(ev5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clk (clk),
    .rst (rst),
    .raw (coin10_raw),
    .rise(ev10)
  );

  acc_state_e    state_q, state_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [1:0]    code_q, code_d;
  logic          rej_q, rej_d;
  logic          push, pop, full;

  assign any_ev  = ev5 | ev10;
  assign both_ev = ev5 & ev10;
  assign full    = (cnt_q == CW'(DEPTH));

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    code_d  = COIN_NONE;
    rej_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (both_ev || (any_ev && full)) begin
          rej_d = 1'b1;
        end else if (any_ev) begin
          push = 1'b1;
        end
        if (push) begin
          idle_d = '0;
        end else if (cnt_q != '0 && idle_q != IW'(IDLE_TIMEOUT)) begin
          idle_d = idle_q + 1'b1;
        end
        // The first code is loaded on the way into DRAIN so it is
        // already on coin_code during the first DRAIN cycle.
        if (full || (!push && cnt_q != '0 &&
                     idle_d == IW'(IDLE_TIMEOUT))) begin
          state_d = DRAIN;
          pop     = 1'b1;
          idle_d  = '0;
        end
      end
      DRAIN: begin
        rej_d = any_ev;
        if (cnt_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = GUARD;
        end
      end
      GUARD: begin
        rej_d   = any_ev;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (push) begin
      mem_d[wr_q] = ev5 ? COIN_5 : COIN_10;
      wr_d        = inc_ptr(wr_q);
      cnt_d       = cnt_q + 1'b1;
    end
    if (pop) begin
      code_d = mem_q[rd_q];
      rd_d   = inc_ptr(rd_q);
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= COIN_NONE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      code_q  <= COIN_NONE;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      code_q  <= code_d;
      rej_q   <= rej_d;
    end
  end

  assign coin_code = code_q;
  assign busy      = (state_q != COLLECT);
  assign reject    = rej_q;

`ifdef COIN_REJECT_COUNT_EN
  logic [7:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (rej_d && rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end

  assign reject_cnt = rcnt_q;
`endif

endmodule
